// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, parity modes
// and a constant clog2 used to size counters and pointers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO with occupancy count; head is visible combinationally.
// Pushes while full and pops while empty are ignored, so callers may gate loosely.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_gen.sv
// Buffered UART transmitter: configurable data bits, parity and stop bits,
// first start bit two cycles after a push into an idle, empty buffer.
module uart_tx_gen
  import uart_pkg::*;
#(
  parameter int CLK        = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_BITS-1:0]       s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       tx,
  output logic                       busy,
  output logic                       done,
  output logic [clog2(FIFO_DEPTH):0] level
);

  localparam int BAUD_CNT_MAX = CLK / UART_BPS;
  localparam int CW = clog2(BAUD_CNT_MAX);
  localparam int IW = clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9 ||
      (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      BAUD_CNT_MAX < 4) begin : g_bad_param
    $error("uart_tx_gen: illegal parameter combination");
  end

  uart_state_t          state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] sh;
  logic                 par_bit;
  logic [DATA_BITS-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 bit_end;
  logic                 pre_end;
  logic                 last_stop;

  assign bit_end   = (cnt == CW'(BAUD_CNT_MAX - 1));
  assign pre_end   = (cnt == CW'(BAUD_CNT_MAX - 2));
  assign last_stop = (bit_idx == IW'(STOP_BITS - 1));
  assign pop       = !empty && ((state == ST_IDLE) ||
                                (state == ST_STOP && bit_end && last_stop));
  assign s_ready   = !full;
  assign busy      = (state != ST_IDLE) || !empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // tx is loaded with the value of the bit about to start, so it changes
  // on the same edge as the state and never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      done    <= 1'b0;
    end else begin
      // Raised one cycle early so the pulse coincides with the final stop cycle.
      done <= (state == ST_STOP) && last_stop && pre_end;

      if (state == ST_IDLE || bit_end) cnt <= '0;
      else                             cnt <= cnt + CW'(1);

      case (state)
        ST_IDLE: begin
          if (!empty) begin
            sh      <= head;
            par_bit <= (PARITY == PAR_EVEN) ? ^head : ~^head;
            state   <= ST_START;
            tx      <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx      <= sh[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            sh <= sh >> 1;
            if (bit_idx == IW'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              if (PARITY != PAR_NONE) begin
                state <= ST_PAR;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IW'(1);
              tx      <= sh[1];
            end
          end
        end
        ST_PAR: begin
          if (bit_end) begin
            state   <= ST_STOP;
            bit_idx <= '0;
            tx      <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (!last_stop) begin
              bit_idx <= bit_idx + IW'(1);
            end else if (!empty) begin
              sh      <= head;
              par_bit <= (PARITY == PAR_EVEN) ? ^head : ~^head;
              state   <= ST_START;
              tx      <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_gen.md
Name: uart_tx_gen

Overview:
Parametrised UART transmitter, the successor to the team's fixed 8N1 serialiser. It buffers input words in an internal FIFO behind a valid/ready handshake and supports configurable data width, parity and stop bits. Each word is latched at dequeue, so the input may change after acceptance. It sits between a byte/word producer (protocol formatter, debug streamer) and the board TX pin.

Parameters:
CLK, 50_000_000, system clock frequency in Hz
UART_BPS, 9600, baud rate; BAUD_CNT_MAX = CLK / UART_BPS cycles per bit (integer division, must be >= 4)
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 8, word buffer depth, power of 2, >= 2

Ports:
clk  in  1  system clock, all logic on the rising edge
rst  in  1  asynchronous, active-high reset
s_data  in  DATA_BITS  word to send
s_valid  in  1  s_data is valid
s_ready  out  1  FIFO can accept; equals !full (combinational from the FIFO count)
tx  out  1  serial line, idle high
busy  out  1  high while a frame is in progress or the FIFO is non-empty
done  out  1  one-cycle pulse at the end of each frame's last stop bit
level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: tx = 1, busy = 0, done = 0, level = 0, s_ready = 1. The FIFO is flushed and the FSM goes to IDLE.
- Reset mid-frame: tx returns high asynchronously and the frame is abandoned. No done pulse is issued.
- Push: the FIFO accepts a word when s_valid && s_ready. While full, s_ready = 0 and s_data is ignored.
- Simultaneous push and pop is legal when not full; level is unchanged in that cycle.
- Baud counter:
  - Width clog2(BAUD_CNT_MAX).
  - Counts 0..BAUD_CNT_MAX-1 while not IDLE.
  - Clears on entering START.
  - bit_end is asserted when count == BAUD_CNT_MAX-1.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into shift register sh and go to START. Compute the parity bit: even = ^word, odd = ~^word.
  - START: tx = 0 for one bit time. On bit_end go to DATA with bit index = 0.
  - DATA: tx = sh[0]. On bit_end, shift right and increment the index. After DATA_BITS bits, go to PAR if PARITY != 0, otherwise go to STOP.
  - PAR: tx = the stored parity bit for one bit time, then go to STOP.
  - STOP: tx = 1 for STOP_BITS bit times. On the final bit_end, assert done for one cycle. If the FIFO is non-empty, pop and go directly to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- tx is registered and glitch-free.
- Latency: a push into an empty FIFO while IDLE at cycle N gives tx = 0 from cycle N+2. The first start bit lasts exactly BAUD_CNT_MAX cycles.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * BAUD_CNT_MAX cycles.
- Illegal parameters (DATA_BITS outside 5..9, PARITY > 2, STOP_BITS not 1/2, FIFO_DEPTH not a power of 2) are caught by an elaboration-time check.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state encoding;
  - parity constants PAR_NONE / PAR_ODD / PAR_EVEN;
  - a clog2 helper function.
- Sub-module uart_tx_fifo: synchronous FIFO of DATA_BITS × FIFO_DEPTH, with wrapping read/write pointers, an occupancy counter, and full/empty flags. It is reusable by the future RX path.
- The top level contains the baud counter, FSM and shifter.

Test Plan:
All scenarios use CLK=16, UART_BPS=1, giving BAUD_CNT_MAX = 16.

- Reset idle: assert rst, then release. Required: tx = 1, s_ready = 1, level = 0, busy = 0, and tx stays high for 100 cycles.
- 8N1: push 0xA5 at cycle N. Required: tx low over cycles N+2..N+17, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then stop high. done pulses at cycle N+161.
- 8E2 and 7O1: 8E2 with 0x07 gives parity bit 1 and two stop bit times (frame 192 cycles). 7O1 with 0x7F gives parity bit 0 (frame 160 cycles).
- FIFO full and back-to-back: with FIFO_DEPTH=4, push 6 words without waiting. Required:
  - s_ready drops once level reaches 4;
  - the source holds the rejected word until s_ready returns;
  - frames follow with no idle gap and appear in push order;
  - done gives 6 pulses spaced 160 cycles apart.
- Input hold-off: push 0x3C, then change s_data to 0xFF while s_valid = 0. Required: the transmitted frame still carries 0x3C.
- Reset mid-frame: assert rst during the DATA state. Required: tx = 1 immediately, level = 0, and no done pulse. After release, a new push of 0x55 transmits correctly.
